spdif_tx_varclk: RTL and testbench
==================================

Name: spdif_tx_varclk

Overview:
S/PDIF (IEC 60958) transmitter: serialises 24-bit PCM samples plus per-block channel-status and user bits into a biphase-mark-coded line signal. The halfbit period is programmable in system clocks, so one fixed system clock covers 32 kHz to 192 kHz. It sits at the output of the mixer datapath and is the transmit counterpart of the S/PDIF receiver/DAI.

Parameters:
MAX_CLK_PER_HALFBIT_LOG2, 5, width of clk_per_halfbit (max 31 clocks per halfbit)
MIN_CLK_PER_HALFBIT, 2, smaller programmed values are clamped to this

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
enable_i  in  1  1 = transmit; 0 = idle, line held low
clk_per_halfbit  in  MAX_CLK_PER_HALFBIT_LOG2  system clocks per BMC halfbit
data_i  in  24  sample, LSB transmitted first
valid_i  in  1  data_i valid
ready_o  out  1  holding register empty; transfer on valid_i && ready_o
udata_i  in  192  user bits for next block, bit n goes with frame n
cdata_i  in  192  channel-status bits for next block
signal_o  out  1  BMC line output, registered
lrck_o  out  1  1 during channel A (B/M preamble) subframe, 0 during channel B (W)
block_start_o  out  1  one-cycle pulse at the start of frame 0
underrun_o  out  1  one-cycle pulse when a subframe starts with no sample available

Behaviour:
- Reset (rst low, async): signal_o=0, lrck_o=0, block_start_o=0, underrun_o=0, ready_o=1 (holding register empty), all counters 0, frame=0, line level=0.
- Timing: the halfbit counter counts 0..cph-1, where cph = max(clk_per_halfbit, MIN_CLK_PER_HALFBIT).
  - cph is sampled only at the subframe boundary; mid-subframe changes take effect at the next subframe.
  - The halfbit index counts 0..63 per subframe. The subframe boundary is the last cycle of halfbit 63.
- Subframe layout (32 slots, 2 halfbits each):
  - slots 0-3: preamble;
  - slots 4-27: data_i[0..23];
  - slot 28: V; slot 29: U = udata[frame]; slot 30: C = cdata[frame];
  - slot 31: P, set so that slots 4-31 carry an even number of ones.
- Preamble patterns (8 halfbits, first halfbit first, for a previous line level of 0): B=11101000, M=11100010, W=11100100. If the previous level is 1, all 8 halfbits are inverted.
  - B: channel A of frame 0. M: channel A of frames 1-191. W: all channel B subframes.
- BMC: each slot toggles the line at its start. A data bit of 1 also toggles at mid-slot.
- signal_o changes on the first clock of each halfbit, registered: latency one clk after the internal halfbit edge.
- Sequencing: subframe order is A,B. The frame counter runs 0..191 and wraps to 0 after channel B of frame 191.
  - block_start_o pulses on the first cycle of frame 0 channel A.
  - cdata_i/udata_i are latched into shadow registers at that same cycle and are held for the whole block.
  - Channels A and B of a frame use the same U and C bit.
- Holding buffer (1 entry): ready_o = !full. A transfer sets full and captures data_i.
- At the boundary:
  - If full: move the held sample to the shift register and clear full.
  - If empty and valid_i is high in that same cycle: data_i goes directly to the shift register; full stays 0.
  - Otherwise (underrun): transmit sample 0 with V=1 and pulse underrun_o. In all other cases V=0.
- Enable:
  - While enable_i=0: signal_o=0, counters held at 0, frame=0, lrck_o=0. The holding buffer still accepts one sample.
  - On the first cycle with enable_i=1, treat as a boundary: load the sample and start frame 0 channel A with preamble B, previous level 0.
  - Dropping enable_i mid-subframe aborts immediately (next cycle signal_o=0), with no partial-subframe completion.
- Async reset mid-subframe: immediate return to the reset state. The held sample is discarded.

Test Plan:
- cph=4, enable=1, valid_i always high with data_i=24'h000001 → first subframe halfbits = 11101000 then slot4 "10" (1-bit, starts high after preamble end level 0). P=1 in slot 31 (only V=0,U=0,C=0 plus one data 1). Subframe length 256 clks.
- Block of 384 subframes, cdata_i[0]=1, cdata_i[191]=1, others 0 → C=1 only in frame 0 and frame 191 (both channels); B preamble exactly every 384 subframes; block_start_o pulses once per 98304 clks at cph=4.
- valid_i held low for channel B of frame 3 → that subframe carries data 0, V=1, underrun_o one pulse. Surrounding subframes V=0 with correct data.
- clk_per_halfbit changed 4→24 mid-subframe → current subframe stays at 4 clks/halfbit, next at 24. clk_per_halfbit=0 or 1 → 2 clks/halfbit.
- Random data for 1000 subframes, checked by the existing receiver in loopback at cph 4/8/16 → receiver locks, data_o equals sent samples, even parity every subframe.
- rst pulsed low mid-slot 12, then enable toggled 0→1 → signal_o=0 and ready_o=1 asynchronously. The restart begins with preamble B, frame 0.

Source files
------------

// File: rtl/spdif_tx_varclk.sv
// rtl/spdif_tx_varclk.sv - S/PDIF biphase-mark transmitter with programmable halfbit period
// One-entry holding buffer feeds a 64-halfbit subframe sequencer; U/C bits come from per-block shadows.
module spdif_tx_varclk #(
  parameter int MAX_CLK_PER_HALFBIT_LOG2 = 5,
  parameter int MIN_CLK_PER_HALFBIT      = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable_i,
  input  logic [MAX_CLK_PER_HALFBIT_LOG2-1:0] clk_per_halfbit,
  input  logic [23:0]                         data_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic [191:0]                        udata_i,
  input  logic [191:0]                        cdata_i,
  output logic                                signal_o,
  output logic                                lrck_o,
  output logic                                block_start_o,
  output logic                                underrun_o
);

  localparam int W = MAX_CLK_PER_HALFBIT_LOG2;
  localparam logic [W-1:0] MIN_CPH = W'(MIN_CLK_PER_HALFBIT);

  typedef enum logic [0:0] {ST_IDLE, ST_RUN} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   cph_q, cph_d;
  logic [5:0]     idx_q, idx_d;
  logic [7:0]     frame_q, frame_d;
  logic           chan_q, chan_d;
  logic [24:0]    sf_q, sf_d;
  logic           sig_q, sig_d;
  logic           pre_lvl_q, pre_lvl_d;
  logic           full_q, full_d;
  logic [23:0]    hold_q, hold_d;
  logic [191:0]   ushadow_q, ushadow_d;
  logic [191:0]   cshadow_q, cshadow_d;
  logic           bstart_q, bstart_d;
  logic           under_q, under_d;

  logic [W-1:0]   cph_in;
  logic           last_hb, start, boundary, load;
  logic [4:0]     slot;
  logic [7:0]     pat;
  logic           u_bit, c_bit, slot_bit, hb_val;

  assign cph_in   = (clk_per_halfbit < MIN_CPH) ? MIN_CPH : clk_per_halfbit;
  assign last_hb  = (cnt_q == cph_q - W'(1));
  assign start    = (state_q == ST_IDLE) && enable_i;
  assign boundary = (state_q == ST_RUN) && enable_i && (idx_q == 6'd63) && last_hb;
  assign load     = start || boundary;
  assign slot     = idx_q[5:1];
  assign u_bit    = ushadow_q[frame_q];
  assign c_bit    = cshadow_q[frame_q];

  // Value of the halfbit that begins this cycle; patterns are written for a previous level of 0.
  always_comb begin
    pat      = 8'b11100100;
    slot_bit = 1'b0;
    hb_val   = 1'b0;
    if (!chan_q) pat = (frame_q == 8'd0) ? 8'b11101000 : 8'b11100010;
    if (slot == 5'd29)      slot_bit = u_bit;
    else if (slot == 5'd30) slot_bit = c_bit;
    else if (slot == 5'd31) slot_bit = (^sf_q) ^ u_bit ^ c_bit;
    else if (slot >= 5'd4)  slot_bit = sf_q[slot - 5'd4];
    if (idx_q < 6'd8)   hb_val = pat[3'd7 - idx_q[2:0]] ^ pre_lvl_q;
    else if (idx_q[0])  hb_val = slot_bit ? ~sig_q : sig_q;
    else                hb_val = ~sig_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cph_d     = cph_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    chan_d    = chan_q;
    sf_d      = sf_q;
    sig_d     = sig_q;
    pre_lvl_d = pre_lvl_q;
    full_d    = full_q;
    hold_d    = hold_q;
    ushadow_d = ushadow_q;
    cshadow_d = cshadow_q;
    bstart_d  = 1'b0;
    under_d   = 1'b0;

    if (valid_i && !full_q) begin
      full_d = 1'b1;
      hold_d = data_i;
    end

    case (state_q)
      ST_IDLE: begin
        sig_d   = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
        frame_d = '0;
        chan_d  = 1'b0;
        if (enable_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
          sig_d   = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
          frame_d = '0;
          chan_d  = 1'b0;
        end else if (!boundary) begin
          if (last_hb) begin
            cnt_d = '0;
            idx_d = idx_q + 6'd1;
          end else begin
            cnt_d = cnt_q + W'(1);
          end
          if (cnt_q == '0) sig_d = hb_val;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      cnt_d = '0;
      idx_d = '0;
      cph_d = cph_in;
      if (start) begin
        frame_d   = '0;
        chan_d    = 1'b0;
        pre_lvl_d = 1'b0;
      end else begin
        pre_lvl_d = sig_q;
        chan_d    = ~chan_q;
        if (chan_q) frame_d = (frame_q == 8'd191) ? 8'd0 : frame_q + 8'd1;
      end
      if (frame_d == 8'd0 && !chan_d) begin
        bstart_d  = 1'b1;
        ushadow_d = udata_i;
        cshadow_d = cdata_i;
      end
      // A sample offered in the boundary cycle itself bypasses the holding register.
      if (full_q) begin
        sf_d   = {1'b0, hold_q};
        full_d = 1'b0;
      end else if (valid_i) begin
        sf_d   = {1'b0, data_i};
        full_d = 1'b0;
      end else begin
        sf_d    = {1'b1, 24'h0};
        under_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cph_q     <= MIN_CPH;
      idx_q     <= '0;
      frame_q   <= '0;
      chan_q    <= 1'b0;
      sf_q      <= '0;
      sig_q     <= 1'b0;
      pre_lvl_q <= 1'b0;
      full_q    <= 1'b0;
      hold_q    <= '0;
      ushadow_q <= '0;
      cshadow_q <= '0;
      bstart_q  <= 1'b0;
      under_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cph_q     <= cph_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      chan_q    <= chan_d;
      sf_q      <= sf_d;
      sig_q     <= sig_d;
      pre_lvl_q <= pre_lvl_d;
      full_q    <= full_d;
      hold_q    <= hold_d;
      ushadow_q <= ushadow_d;
      cshadow_q <= cshadow_d;
      bstart_q  <= bstart_d;
      under_q   <= under_d;
    end
  end

  assign ready_o       = !full_q;
  assign signal_o      = sig_q;
  assign lrck_o        = (state_q == ST_RUN) && !chan_q;
  assign block_start_o = bstart_q;
  assign underrun_o    = under_q;

endmodule

// File: tb/tb_spdif_tx_varclk.sv
// tb/tb_spdif_tx_varclk.sv - directed self-checking bench for spdif_tx_varclk
module tb_spdif_tx_varclk;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable_i;
  logic [4:0]   cph_i;
  logic [23:0]  data_i;
  logic         valid_i;
  logic         ready_o;
  logic [191:0] udata_i;
  logic [191:0] cdata_i;
  logic         signal_o;
  logic         lrck_o;
  logic         block_start_o;
  logic         underrun_o;

  int n_cmp = 0;
  int n_bad = 0;
  int und_cnt = 0;
  int bs_cnt = 0;
  int cyc = 0;
  int bs_last = 0;
  int bs_prev = 0;

  spdif_tx_varclk #(.MAX_CLK_PER_HALFBIT_LOG2(5), .MIN_CLK_PER_HALFBIT(2)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .clk_per_halfbit(cph_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .udata_i(udata_i), .cdata_i(cdata_i), .signal_o(signal_o), .lrck_o(lrck_o),
    .block_start_o(block_start_o), .underrun_o(underrun_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (underrun_o) und_cnt = und_cnt + 1;
    if (block_start_o) begin
      bs_cnt  = bs_cnt + 1;
      bs_prev = bs_last;
      bs_last = cyc;
    end
  end

  // Expected halfbits of one subframe, index 0 first on the line, previous level 0.
  function automatic logic [63:0] exp_sf(input int pt, input logic [23:0] d,
                                         input logic v, input logic u, input logic c);
    logic [7:0]  pat;
    logic [27:0] bits;
    logic        lvl;
    logic [63:0] r;
    pat = (pt == 0) ? 8'b11101000 : (pt == 1) ? 8'b11100010 : 8'b11100100;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = pat[7-i];
    bits = {^{d, v, u, c}, c, u, v, d};
    lvl = 1'b0;
    for (int s = 0; s < 28; s++) begin
      lvl = ~lvl;
      r[8+2*s] = lvl;
      if (bits[s]) lvl = ~lvl;
      r[9+2*s] = lvl;
    end
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b0; enable_i = 1'b0; valid_i = 1'b0; data_i = '0;
    cph_i = 5'd4; udata_i = '0; cdata_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Returns at the first negedge where halfbit 0 of frame 0 channel A is on the line.
  task automatic wait_bs(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (block_start_o) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s block_start: got no pulse within 200 cycles, required one", name);
    end
    @(negedge clk);
  endtask

  // Samples 64 halfbits; at halfbit 32 applies new valid/data/cph and samples lrck.
  task automatic cap_sf(input int cph, input logic mv, input logic [23:0] md,
                        input logic [4:0] mc, output logic [63:0] hb, output logic lr);
    hb = '0;
    lr = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (k == 32) begin
        valid_i = mv; data_i = md; cph_i = mc; lr = lrck_o;
      end
      hb[k] = signal_o;
      repeat (cph) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; enable_i = 1'b0; valid_i = 1'b0; data_i = '0;
    cph_i = 5'd4; udata_i = '0; cdata_i = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (signal_o !== 1'b0) begin n_bad++; $display("FAIL reset signal_o: got %b required 0", signal_o); end
    n_cmp++; if (lrck_o !== 1'b0) begin n_bad++; $display("FAIL reset lrck_o: got %b required 0", lrck_o); end
    n_cmp++; if (block_start_o !== 1'b0) begin n_bad++; $display("FAIL reset block_start_o: got %b required 0", block_start_o); end
    n_cmp++; if (underrun_o !== 1'b0) begin n_bad++; $display("FAIL reset underrun_o: got %b required 0", underrun_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset ready_o: got %b required 1", ready_o); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [63:0] hb, e;
    logic lr;
    int u0;
    do_reset();
    data_i = 24'h000001; valid_i = 1'b1;
    @(negedge clk);
    enable_i = 1'b1;
    u0 = und_cnt;
    wait_bs("basic");
    cap_sf(4, 1'b1, 24'h000001, 5'd4, hb, lr);
    n_cmp++; if (hb[9:0] !== 10'b0100010111) begin n_bad++; $display("FAIL basic sf0 head: got %b required 0100010111", hb[9:0]); end
    n_cmp++; if (hb[63:62] !== 2'b01) begin n_bad++; $display("FAIL basic sf0 parity slot: got %b required 01", hb[63:62]); end
    e = exp_sf(0, 24'h000001, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (hb !== e) begin n_bad++; $display("FAIL basic sf0: got %h required %h", hb, e); end
    n_cmp++; if (lr !== 1'b1) begin n_bad++; $display("FAIL basic lrck chA: got %b required 1", lr); end
    cap_sf(4, 1'b1, 24'hFFFFFF, 5'd4, hb, lr);
    e = exp_sf(2, 24'h000001, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (hb !== e) begin n_bad++; $display("FAIL basic sf1: got %h required %h", hb, e); end
    n_cmp++; if (lr !== 1'b0) begin n_bad++; $display("FAIL basic lrck chB: got %b required 0", lr); end
    cap_sf(4, 1'b1, 24'hFFFFFF, 5'd4, hb, lr);
    e = exp_sf(1, 24'h000001, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (hb !== e) begin n_bad++; $display("FAIL basic sf2: got %h required %h", hb, e); end
    cap_sf(4, 1'b1, 24'hFFFFFF, 5'd4, hb, lr);
    e = exp_sf(2, 24'hFFFFFF, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (hb !== e) begin n_bad++; $display("FAIL basic sf3: got %h required %h", hb, e); end
    n_cmp++; if (und_cnt - u0 !== 0) begin n_bad++; $display("FAIL basic underrun count: got %0d required 0", und_cnt - u0); end
  endtask

  task automatic test_underrun();
    logic [63:0] hb, e;
    logic lr;
    int u0;
    logic [23:0] ed [9];
    logic        ev [9];
    logic        mv [9];
    logic [23:0] md [9];
    ed = '{24'h00F00F, 24'h00F00F, 24'h00F00F, 24'h00F00F, 24'h00F00F, 24'h00F00F, 24'h7E0001, 24'h000000, 24'h0C0C0C};
    ev = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    mv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    md = '{24'h00F00F, 24'h00F00F, 24'h00F00F, 24'h00F00F, 24'h7E0001, 24'h7E0001, 24'h7E0001, 24'h0C0C0C, 24'h0C0C0C};
    do_reset();
    data_i = 24'h00F00F; valid_i = 1'b1;
    @(negedge clk);
    enable_i = 1'b1;
    u0 = und_cnt;
    wait_bs("underrun");
    for (int s = 0; s < 9; s++) begin
      cap_sf(4, mv[s], md[s], 5'd4, hb, lr);
      e = exp_sf((s % 2 == 1) ? 2 : (s == 0) ? 0 : 1, ed[s], ev[s], 1'b0, 1'b0);
      n_cmp++; if (hb !== e) begin n_bad++; $display("FAIL underrun sf%0d: got %h required %h", s, hb, e); end
      if (s == 5) begin
        n_cmp++; if (und_cnt - u0 !== 0) begin n_bad++; $display("FAIL underrun early pulses: got %0d required 0", und_cnt - u0); end
      end
    end
    n_cmp++; if (und_cnt - u0 !== 1) begin n_bad++; $display("FAIL underrun pulses: got %0d required 1", und_cnt - u0); end
  endtask

  task automatic test_cph_change();
    logic [63:0] hb, e;
    logic lr;
    do_reset();
    data_i = 24'h800001; valid_i = 1'b1;
    @(negedge clk);
    enable_i = 1'b1;
    wait_bs("cph");
    cap_sf(4, 1'b1, 24'h800001, 5'd24, hb, lr);
    e = exp_sf(0, 24'h800001, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (hb !== e) begin n_bad++; $display("FAIL cph sf0 at 4: got %h required %h", hb, e); end
    cap_sf(24, 1'b1, 24'h800001, 5'd1, hb, lr);
    e = exp_sf(2, 24'h800001, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (hb !== e) begin n_bad++; $display("FAIL cph sf1 at 24: got %h required %h", hb, e); end
    cap_sf(2, 1'b1, 24'h800001, 5'd0, hb, lr);
    e = exp_sf(1, 24'h800001, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (hb !== e) begin n_bad++; $display("FAIL cph sf2 clamp 1: got %h required %h", hb, e); end
    cap_sf(2, 1'b1, 24'h800001, 5'd0, hb, lr);
    e = exp_sf(2, 24'h800001, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (hb !== e) begin n_bad++; $display("FAIL cph sf3 clamp 0: got %h required %h", hb, e); end
  endtask

  task automatic test_block();
    logic [63:0] hb, e;
    logic lr, u, c;
    logic [191:0] old_u, old_c, new_u, new_c;
    int b0, f, pt;
    do_reset();
    old_c = '0; old_c[0] = 1'b1; old_c[191] = 1'b1;
    old_u = '0; old_u[1] = 1'b1; old_u[190] = 1'b1;
    new_c = '0; new_c[0] = 1'b1;
    new_u = '1;
    cdata_i = old_c; udata_i = old_u;
    cph_i = 5'd0; data_i = 24'h5A3C96; valid_i = 1'b1;
    @(negedge clk);
    enable_i = 1'b1;
    wait_bs("block");
    b0 = bs_cnt;
    for (int s = 0; s < 386; s++) begin
      cap_sf(2, 1'b1, 24'h5A3C96, 5'd0, hb, lr);
      f  = (s / 2) % 192;
      pt = (s % 2 == 1) ? 2 : (f == 0) ? 0 : 1;
      u  = (s < 384) ? old_u[f] : new_u[f];
      c  = (s < 384) ? old_c[f] : new_c[f];
      e  = exp_sf(pt, 24'h5A3C96, 1'b0, u, c);
      n_cmp++; if (hb !== e) begin n_bad++; $display("FAIL block sf%0d: got %h required %h", s, hb, e); end
      if (s == 10) begin
        cdata_i = new_c; udata_i = new_u;
      end
    end
    n_cmp++; if (bs_cnt - b0 !== 1) begin n_bad++; $display("FAIL block_start count: got %0d required 1", bs_cnt - b0); end
    n_cmp++; if (bs_last - bs_prev !== 49152) begin n_bad++; $display("FAIL block_start period: got %0d required 49152", bs_last - bs_prev); end
  endtask

  task automatic test_enable_reset();
    logic [63:0] hb, e;
    logic lr;
    do_reset();
    data_i = 24'h001100; valid_i = 1'b1;
    @(negedge clk);
    enable_i = 1'b1;
    wait_bs("rst1");
    repeat (25 * 4 + 1) @(negedge clk);
    e = exp_sf(0, 24'h001100, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (signal_o !== e[25]) begin n_bad++; $display("FAIL slot12 level: got %b required %b", signal_o, e[25]); end
    n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL held ready_o: got %b required 0", ready_o); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (signal_o !== 1'b0) begin n_bad++; $display("FAIL async rst signal_o: got %b required 0", signal_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL async rst ready_o: got %b required 1", ready_o); end
    n_cmp++; if (lrck_o !== 1'b0) begin n_bad++; $display("FAIL async rst lrck_o: got %b required 0", lrck_o); end
    enable_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL discard ready_o: got %b required 1", ready_o); end
    data_i = 24'h00ABCD; valid_i = 1'b1;
    @(negedge clk);
    enable_i = 1'b1;
    wait_bs("rst2");
    cap_sf(4, 1'b1, 24'h00ABCD, 5'd4, hb, lr);
    e = exp_sf(0, 24'h00ABCD, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (hb !== e) begin n_bad++; $display("FAIL restart sf0: got %h required %h", hb, e); end
    n_cmp++; if (signal_o !== 1'b1) begin n_bad++; $display("FAIL pre-abort level: got %b required 1", signal_o); end
    enable_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (signal_o !== 1'b0) begin n_bad++; $display("FAIL abort signal_o: got %b required 0", signal_o); end
    n_cmp++; if (lrck_o !== 1'b0) begin n_bad++; $display("FAIL abort lrck_o: got %b required 0", lrck_o); end
    repeat (5) @(negedge clk);
    enable_i = 1'b1;
    wait_bs("reenable");
    cap_sf(4, 1'b1, 24'h00ABCD, 5'd4, hb, lr);
    n_cmp++; if (hb !== e) begin n_bad++; $display("FAIL reenable sf0: got %h required %h", hb, e); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_cph_change();
    test_block();
    test_enable_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
